// File: rtl/apb_transfer_ctrl_if.sv
// Bus bundle between the AHB-side request logic, the transfer controller and the APB interface.
// The controller takes the slave view; whatever feeds it requests takes the master view.
interface apb_transfer_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
);
    logic              Valid;
    logic              Hwrite;
    logic [ADDR_W-1:0] Haddr;
    logic [NSEL-1:0]   Tempselx;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Prdata;
    logic              Hreadyout;
    logic [DATA_W-1:0] Hrdata;
    logic              Pwrite;
    logic              Penable;
    logic [NSEL-1:0]   Pselx;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;

    modport master (
        output Valid, Hwrite, Haddr, Tempselx, Hwdata, Prdata,
        input  Hreadyout, Hrdata, Pwrite, Penable, Pselx, Paddr, Pwdata
    );

    modport slave (
        input  Valid, Hwrite, Haddr, Tempselx, Hwdata, Prdata,
        output Hreadyout, Hrdata, Pwrite, Penable, Pselx, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_transfer_ctrl.sv
// Sequences one AHB request at a time through the APB SETUP/ENABLE phases,
// stalling the AHB side through Hreadyout until the zero-wait APB access completes.
module apb_transfer_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    apb_transfer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WWAIT  = 2'd1,
        SETUP  = 2'd2,
        ENABLE = 2'd3
    } state_t;

    state_t            state;
    logic [NSEL-1:0]   pend_sel;
    logic [NSEL-1:0]   pselx_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              pwrite_r;
    logic              penable_r;
    logic              ready;
    logic              accept;

    // A new request can only land while the bus is idle or finishing its ENABLE phase.
    assign ready  = (state == IDLE) || (state == ENABLE);
    assign accept = bus.Valid && ready && (bus.Tempselx != '0);

    assign bus.Hreadyout = ready;
    assign bus.Hrdata    = (state == ENABLE && !pwrite_r) ? bus.Prdata : '0;
    assign bus.Pselx     = pselx_r;
    assign bus.Paddr     = paddr_r;
    assign bus.Pwdata    = pwdata_r;
    assign bus.Pwrite    = pwrite_r;
    assign bus.Penable   = penable_r;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= IDLE;
            pend_sel  <= '0;
            pselx_r   <= '0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pwrite_r  <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            case (state)
                IDLE, ENABLE: begin
                    penable_r <= 1'b0;
                    if (accept) begin
                        paddr_r  <= bus.Haddr;
                        pwrite_r <= bus.Hwrite;
                        pend_sel <= bus.Tempselx;
                        // Writes spend one cycle collecting Hwdata before SETUP.
                        if (bus.Hwrite) begin
                            state   <= WWAIT;
                            pselx_r <= '0;
                        end else begin
                            state   <= SETUP;
                            pselx_r <= bus.Tempselx;
                        end
                    end else begin
                        state   <= IDLE;
                        pselx_r <= '0;
                    end
                end
                WWAIT: begin
                    pwdata_r <= bus.Hwdata;
                    pselx_r  <= pend_sel;
                    state    <= SETUP;
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state     <= ENABLE;
                end
                default: begin
                    state     <= IDLE;
                    pselx_r   <= '0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_transfer_ctrl.sv
// Directed bench for apb_transfer_ctrl: each task drives one scenario and
// compares outputs against hand-computed values one cycle at a time.
module tb_apb_transfer_ctrl;

    logic Hclk;
    logic Hresetn;
    int   n_checks;
    int   n_pass;

    apb_transfer_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) bus ();

    apb_transfer_ctrl #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus.slave)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Outputs are sampled and inputs changed 1ns after each rising edge.
    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset();
        bus.Prdata = 32'h55;
        n_checks++; if (bus.Hreadyout !== 1'b1) $display("[TB] FAIL reset_hready: got %b expected 1", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL reset_pselx: got %b expected 000", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL reset_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Paddr !== 32'h0) $display("[TB] FAIL reset_paddr: got %h expected 0", bus.Paddr); else n_pass++;
        n_checks++; if (bus.Pwdata !== 32'h0) $display("[TB] FAIL reset_pwdata: got %h expected 0", bus.Pwdata); else n_pass++;
        n_checks++; if (bus.Hrdata !== 32'h0) $display("[TB] FAIL reset_hrdata: got %h expected 0", bus.Hrdata); else n_pass++;
    endtask

    task automatic test_read();
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h8000_0010;
        bus.Tempselx = 3'b001; bus.Prdata = 32'd25;
        step();
        bus.Valid = 1'b0;
        n_checks++; if (bus.Pselx !== 3'b001) $display("[TB] FAIL read_setup_pselx: got %b expected 001", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL read_setup_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b0) $display("[TB] FAIL read_setup_hready: got %b expected 0", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Paddr !== 32'h8000_0010) $display("[TB] FAIL read_setup_paddr: got %h expected 80000010", bus.Paddr); else n_pass++;
        n_checks++; if (bus.Pwrite !== 1'b0) $display("[TB] FAIL read_setup_pwrite: got %b expected 0", bus.Pwrite); else n_pass++;
        n_checks++; if (bus.Hrdata !== 32'h0) $display("[TB] FAIL read_setup_hrdata: got %h expected 0", bus.Hrdata); else n_pass++;
        step();
        n_checks++; if (bus.Penable !== 1'b1) $display("[TB] FAIL read_enable_penable: got %b expected 1", bus.Penable); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b001) $display("[TB] FAIL read_enable_pselx: got %b expected 001", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Hrdata !== 32'd25) $display("[TB] FAIL read_enable_hrdata: got %0d expected 25", bus.Hrdata); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b1) $display("[TB] FAIL read_enable_hready: got %b expected 1", bus.Hreadyout); else n_pass++;
        step();
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL read_idle_pselx: got %b expected 000", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL read_idle_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Hrdata !== 32'h0) $display("[TB] FAIL read_idle_hrdata: got %h expected 0", bus.Hrdata); else n_pass++;
        n_checks++; if (bus.Paddr !== 32'h8000_0010) $display("[TB] FAIL read_idle_paddr: got %h expected 80000010", bus.Paddr); else n_pass++;
    endtask

    task automatic test_write();
        bus.Valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h8400_0004; bus.Tempselx = 3'b010;
        step();
        bus.Valid = 1'b0; bus.Hwdata = 32'hDEAD_BEEF;
        n_checks++; if (bus.Hreadyout !== 1'b0) $display("[TB] FAIL write_wwait_hready: got %b expected 0", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL write_wwait_pselx: got %b expected 000", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Pwrite !== 1'b1) $display("[TB] FAIL write_wwait_pwrite: got %b expected 1", bus.Pwrite); else n_pass++;
        step();
        bus.Hwdata = 32'h0;
        n_checks++; if (bus.Pwdata !== 32'hDEAD_BEEF) $display("[TB] FAIL write_setup_pwdata: got %h expected deadbeef", bus.Pwdata); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b010) $display("[TB] FAIL write_setup_pselx: got %b expected 010", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL write_setup_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b0) $display("[TB] FAIL write_setup_hready: got %b expected 0", bus.Hreadyout); else n_pass++;
        step();
        n_checks++; if (bus.Penable !== 1'b1) $display("[TB] FAIL write_enable_penable: got %b expected 1", bus.Penable); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b1) $display("[TB] FAIL write_enable_hready: got %b expected 1", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Hrdata !== 32'h0) $display("[TB] FAIL write_enable_hrdata: got %h expected 0", bus.Hrdata); else n_pass++;
        n_checks++; if (bus.Pwdata !== 32'hDEAD_BEEF) $display("[TB] FAIL write_enable_pwdata: got %h expected deadbeef", bus.Pwdata); else n_pass++;
        step();
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL write_idle_pselx: got %b expected 000", bus.Pselx); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.Valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h0000_1000; bus.Tempselx = 3'b100;
        step();
        bus.Valid = 1'b0; bus.Hwdata = 32'h1234_5678;
        step();
        step();
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h0000_2000; bus.Tempselx = 3'b001;
        n_checks++; if (bus.Penable !== 1'b1) $display("[TB] FAIL b2b_wr_enable: got %b expected 1", bus.Penable); else n_pass++;
        step();
        bus.Valid = 1'b0; bus.Prdata = 32'h77;
        n_checks++; if (bus.Paddr !== 32'h0000_2000) $display("[TB] FAIL b2b_paddr: got %h expected 00002000", bus.Paddr); else n_pass++;
        n_checks++; if (bus.Pwrite !== 1'b0) $display("[TB] FAIL b2b_pwrite: got %b expected 0", bus.Pwrite); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL b2b_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b001) $display("[TB] FAIL b2b_pselx: got %b expected 001", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b0) $display("[TB] FAIL b2b_hready: got %b expected 0", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Pwdata !== 32'h1234_5678) $display("[TB] FAIL b2b_pwdata_hold: got %h expected 12345678", bus.Pwdata); else n_pass++;
        step();
        n_checks++; if (bus.Hrdata !== 32'h77) $display("[TB] FAIL b2b_hrdata: got %h expected 77", bus.Hrdata); else n_pass++;
        step();
    endtask

    task automatic test_no_select();
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h0000_FFFF; bus.Tempselx = 3'b000;
        step();
        step();
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL nosel_pselx: got %b expected 000", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b1) $display("[TB] FAIL nosel_hready: got %b expected 1", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL nosel_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Paddr !== 32'h0000_2000) $display("[TB] FAIL nosel_paddr: got %h expected 00002000", bus.Paddr); else n_pass++;
        bus.Valid = 1'b0;
    endtask

    task automatic test_valid_during_busy();
        bus.Valid = 1'b1; bus.Hwrite = 1'b1; bus.Haddr = 32'h0000_3000; bus.Tempselx = 3'b010;
        step();
        bus.Hwdata = 32'hCAFE_F00D;
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h0000_4000; bus.Tempselx = 3'b001;
        step();
        n_checks++; if (bus.Paddr !== 32'h0000_3000) $display("[TB] FAIL busy_setup_paddr: got %h expected 00003000", bus.Paddr); else n_pass++;
        n_checks++; if (bus.Pwrite !== 1'b1) $display("[TB] FAIL busy_setup_pwrite: got %b expected 1", bus.Pwrite); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b010) $display("[TB] FAIL busy_setup_pselx: got %b expected 010", bus.Pselx); else n_pass++;
        step();
        bus.Valid = 1'b0;
        n_checks++; if (bus.Paddr !== 32'h0000_3000) $display("[TB] FAIL busy_enable_paddr: got %h expected 00003000", bus.Paddr); else n_pass++;
        n_checks++; if (bus.Penable !== 1'b1) $display("[TB] FAIL busy_enable_penable: got %b expected 1", bus.Penable); else n_pass++;
        n_checks++; if (bus.Pwdata !== 32'hCAFE_F00D) $display("[TB] FAIL busy_enable_pwdata: got %h expected cafef00d", bus.Pwdata); else n_pass++;
        step();
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL busy_idle_pselx: got %b expected 000", bus.Pselx); else n_pass++;
    endtask

    task automatic test_reset_mid_enable();
        bus.Valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h0000_5000; bus.Tempselx = 3'b100;
        bus.Prdata = 32'h99;
        step();
        bus.Valid = 1'b0;
        step();
        n_checks++; if (bus.Penable !== 1'b1) $display("[TB] FAIL rst_pre_penable: got %b expected 1", bus.Penable); else n_pass++;
        #2;
        Hresetn = 1'b0;
        #1;
        n_checks++; if (bus.Penable !== 1'b0) $display("[TB] FAIL rst_mid_penable: got %b expected 0", bus.Penable); else n_pass++;
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL rst_mid_pselx: got %b expected 000", bus.Pselx); else n_pass++;
        n_checks++; if (bus.Paddr !== 32'h0) $display("[TB] FAIL rst_mid_paddr: got %h expected 0", bus.Paddr); else n_pass++;
        n_checks++; if (bus.Pwdata !== 32'h0) $display("[TB] FAIL rst_mid_pwdata: got %h expected 0", bus.Pwdata); else n_pass++;
        n_checks++; if (bus.Hreadyout !== 1'b1) $display("[TB] FAIL rst_mid_hready: got %b expected 1", bus.Hreadyout); else n_pass++;
        n_checks++; if (bus.Hrdata !== 32'h0) $display("[TB] FAIL rst_mid_hrdata: got %h expected 0", bus.Hrdata); else n_pass++;
        @(negedge Hclk);
        Hresetn = 1'b1;
        step();
        n_checks++; if (bus.Pselx !== 3'b000) $display("[TB] FAIL rst_after_pselx: got %b expected 000", bus.Pselx); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        Hresetn  = 1'b0;
        bus.Valid = 1'b0; bus.Hwrite = 1'b0; bus.Haddr = '0;
        bus.Tempselx = '0; bus.Hwdata = '0; bus.Prdata = '0;
        #23;
        test_reset();
        Hresetn = 1'b1;
        step();
        test_read();
        test_write();
        test_back_to_back();
        test_no_select();
        test_valid_during_busy();
        test_reset_mid_enable();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
